btb_branch_predictor: RTL and testbench

//  Parametrised branch target buffer with per-entry saturating direction counters, used by the IF stage.

---
 rtl/btb_branch_predictor.sv | 113 +++++++++++
 tb/tb_btb_branch_predictor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters and round-robin allocation.
// Lookup is combinational on the fetch PC; resolved branches train the table on the next rising edge.
module btb_branch_predictor #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_en,
    input  logic                       btb_clr,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [31:0]                instr,
    output logic [ADDR_W-1:0]          pc_next,
    output logic                       pred_taken,
    output logic                       pred_hit,
    input  logic                       upd_valid,
    input  logic [ADDR_W-1:0]          upd_pc,
    input  logic                       upd_taken,
    input  logic [ADDR_W-1:0]          upd_target,
    output logic [$clog2(ENTRIES)-1:0] alloc_ptr
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    logic              valid_q  [ENTRIES];
    logic [ADDR_W-1:0] tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [IDX_W-1:0]  ptr_q;

    logic              look_hit;
    logic [IDX_W-1:0]  look_idx;
    logic              upd_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic              is_jump;
    logic [ADDR_W-1:0] pc_plus4;

    // Two independent CAM searches; the first match from index 0 wins.
    always_comb begin
        look_hit = 1'b0;
        look_idx = '0;
        upd_hit  = 1'b0;
        upd_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!look_hit && valid_q[i] && tag_q[i] == pc) begin
                look_hit = 1'b1;
                look_idx = IDX_W'(i);
            end
            if (!upd_hit && valid_q[i] && tag_q[i] == upd_pc) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    assign is_jump  = (instr[31:26] == 6'b000010);
    assign pc_plus4 = pc + ADDR_W'(4);

    always_comb begin
        pc_next    = pc_plus4;
        pred_taken = 1'b0;
        pred_hit   = look_hit;
        if (pred_en) begin
            if (is_jump) begin
                pc_next    = {pc[ADDR_W-1:28], instr[25:0], 2'b00};
                pred_taken = 1'b1;
            end else if (look_hit && cnt_q[look_idx][CNT_W-1]) begin
                pc_next    = target_q[look_idx];
                pred_taken = 1'b1;
            end
        end
    end

    // Clear drops any concurrent update; counters and pointer survive a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (btb_clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                    if (cnt_q[upd_idx] != CNT_MAX) begin
                        cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_W'(1);
                    end
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                valid_q[ptr_q]  <= 1'b1;
                tag_q[ptr_q]    <= upd_pc;
                target_q[ptr_q] <= upd_target;
                cnt_q[ptr_q]    <= CNT_WEAK;
                ptr_q           <= ptr_q + IDX_W'(1);
            end
        end
    end

    assign alloc_ptr = ptr_q;

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Self-checking bench: directed spec scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural table model.
module tb_btb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_en;
    logic        btb_clr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_next;
    logic        pred_taken;
    logic        pred_hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [2:0]  alloc_ptr;

    int tests = 0;
    int fails = 0;

    // Behavioural model: table of entries as plain arrays, counters as integers.
    bit          m_val [8];
    logic [31:0] m_tag [8];
    logic [31:0] m_tgt [8];
    int          m_cnt [8];
    int          m_ptr;

    btb_branch_predictor #(.ENTRIES(8), .ADDR_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .pred_en(pred_en), .btb_clr(btb_clr),
        .pc(pc), .instr(instr), .pc_next(pc_next), .pred_taken(pred_taken),
        .pred_hit(pred_hit), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .alloc_ptr(alloc_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_find(input logic [31:0] p);
        for (int i = 0; i < 8; i++) begin
            if (m_val[i] && m_tag[i] == p) return i;
        end
        return -1;
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 8; i++) begin
            m_val[i] = 0;
            m_cnt[i] = 0;
        end
        m_ptr = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (btb_clr) begin
                for (int i = 0; i < 8; i++) m_val[i] = 0;
            end else if (upd_valid) begin
                int k;
                k = model_find(upd_pc);
                if (k >= 0) begin
                    if (upd_taken) begin
                        m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
                        m_tgt[k] = upd_target;
                    end else begin
                        m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_val[m_ptr] = 1;
                    m_tag[m_ptr] = upd_pc;
                    m_tgt[m_ptr] = upd_target;
                    m_cnt[m_ptr] = 2;
                    m_ptr = (m_ptr + 1) % 8;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model lookup.
    always @(negedge clk) begin
        if (rst_n) begin
            int k;
            logic [31:0] exp_next;
            logic        exp_taken;
            k = model_find(pc);
            exp_next  = pc + 32'd4;
            exp_taken = 1'b0;
            if (pred_en) begin
                if (instr[31:26] == 6'b000010) begin
                    exp_next  = {pc[31:28], instr[25:0], 2'b00};
                    exp_taken = 1'b1;
                end else if (k >= 0 && m_cnt[k] >= 2) begin
                    exp_next  = m_tgt[k];
                    exp_taken = 1'b1;
                end
            end
            check("model pred_hit", {31'd0, pred_hit}, {31'd0, k >= 0});
            check("model pred_taken", {31'd0, pred_taken}, {31'd0, exp_taken});
            check("model pc_next", pc_next, exp_next);
            check("model alloc_ptr", {29'd0, alloc_ptr}, m_ptr);
        end
    end

    task automatic apply_stimulus(input logic pen, input logic clr, input logic [31:0] p,
                                  input logic [31:0] ins, input logic uv, input logic [31:0] up,
                                  input logic ut, input logic [31:0] utgt);
        @(posedge clk);
        #1;
        pred_en = pen; btb_clr = clr; pc = p; instr = ins;
        upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utgt;
    endtask

    task automatic check_output(input string name, input logic hit, input logic tkn, input logic [31:0] nxt);
        #1;
        check({name, " hit"}, {31'd0, pred_hit}, {31'd0, hit});
        check({name, " taken"}, {31'd0, pred_taken}, {31'd0, tkn});
        check({name, " next"}, pc_next, nxt);
    endtask

    task automatic lookup(input logic [31:0] p);
        apply_stimulus(1'b1, 1'b0, p, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pred_en = 1'b1; btb_clr = 1'b0; pc = 32'h0040_0000; instr = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
        #1;
        check_output("reset", 1'b0, 1'b0, 32'h0040_0004);
        check("reset alloc_ptr", {29'd0, alloc_ptr}, 32'd0);
        #10 rst_n = 1'b1;

        // Allocate 0x40 with a same-cycle lookup that must see the old state.
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 1'b1, 32'h80);
        check_output("same-cycle lookup", 1'b0, 1'b0, 32'h44);
        lookup(32'h40);
        check_output("after alloc", 1'b1, 1'b1, 32'h80);
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        check_output("cnt1", 1'b1, 1'b0, 32'h44);
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 1'b1, 32'h90);
        lookup(32'h40);
        check_output("sat at 0 then +1", 1'b1, 1'b0, 32'h44);
        check("alloc_ptr after one alloc", {29'd0, alloc_ptr}, 32'd1);

        // Nine allocations from a fresh table wrap the round-robin pointer.
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'h1100 + 32'(4 * i));
        end
        lookup(32'h100);
        check_output("evicted 0x100", 1'b0, 1'b0, 32'h104);
        check("alloc_ptr after wrap", {29'd0, alloc_ptr}, 32'd1);
        lookup(32'h120);
        check_output("0x120 resident", 1'b1, 1'b1, 32'h1120);
        lookup(32'h104);
        check_output("0x104 resident", 1'b1, 1'b1, 32'h1104);

        apply_stimulus(1'b1, 1'b0, 32'h1000_0010, 32'h0800_0004, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("J predicted", 1'b0, 1'b1, 32'h1000_0010);
        apply_stimulus(1'b0, 1'b0, 32'h1000_0010, 32'h0800_0004, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("J pred_en=0", 1'b0, 1'b0, 32'h1000_0014);
        apply_stimulus(1'b0, 1'b0, 32'h120, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_output("hit pred_en=0", 1'b1, 1'b0, 32'h124);

        // Clear beats a concurrent allocation.
        apply_stimulus(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300);
        lookup(32'h200);
        check_output("clr drops update", 1'b0, 1'b0, 32'h204);
        check("alloc_ptr after clr", {29'd0, alloc_ptr}, 32'd1);
        lookup(32'h120);
        check_output("clr empties 0x120", 1'b0, 1'b0, 32'h124);

        // Async reset mid-cycle with a populated table.
        apply_stimulus(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 32'h500, 1'b1, 32'h600);
        lookup(32'h500);
        check_output("before async reset", 1'b1, 1'b1, 32'h600);
        #2 rst_n = 1'b0;
        check_output("during async reset", 1'b0, 1'b0, 32'h504);
        check("async alloc_ptr", {29'd0, alloc_ptr}, 32'd0);
        pc = 32'hFFFF_FFFC;
        check_output("wrap pc+4", 1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b1;

        // Randomized traffic over a small PC pool to force hits, evictions and saturation.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins[31:26] = 6'b000010;
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                           32'h1000 + 32'(4 * $urandom_range(0, 11)), ins,
                           $urandom_range(0, 1) == 1, 32'h1000 + 32'(4 * $urandom_range(0, 11)),
                           $urandom_range(0, 2) != 0, {$urandom} & 32'hFFFF_FFFC);
            if (n == 300) begin
                #2 rst_n = 1'b0;
                #1;
                check("random async hit", {31'd0, pred_hit}, 32'd0);
                check("random async ptr", {29'd0, alloc_ptr}, 32'd0);
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
